// File: rtl/arm_fetch_unit_pkg.sv
// Shared types and constants for the ARM fetch front end.
package arm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DRAIN
    } fetch_state_t;

    localparam int INS_BYTES = 4;

endpackage

// File: rtl/arm_fetch_unit_if.sv
// Fetch unit bus bundle: instruction memory handshake, execute redirect and
// the decode-side instruction stream.
interface arm_fetch_unit_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_rvalid;
    logic [DW-1:0] imem_rdata;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          ins_valid;
    logic [DW-1:0] ins;
    logic [AW-1:0] ins_pc;
    logic [AW-1:0] ins_pc_plus4;
    logic          ins_ready;

    modport master (
        output imem_req, imem_addr, ins_valid, ins, ins_pc, ins_pc_plus4,
        input  imem_rvalid, imem_rdata, redirect_valid, redirect_pc, ins_ready
    );

    modport slave (
        input  imem_req, imem_addr, ins_valid, ins, ins_pc, ins_pc_plus4,
        output imem_rvalid, imem_rdata, redirect_valid, redirect_pc, ins_ready
    );
endinterface

// File: rtl/arm_fetch_unit_queue.sv
// Prefetch FIFO holding {pc, word} entries; flush wins over push.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [W-1:0]             push_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [W-1:0]             head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && !flush_i && (!full_o || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: the read side is gated by count.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/arm_fetch_unit.sv
// Instruction fetch front end: one outstanding request to a wait-state memory,
// a prefetch queue towards decode, and flush/restart on execute redirects.
module arm_fetch_unit
    import arm_pkg::*;
#(
    parameter int            AW       = 32,
    parameter int            DW       = 32,
    parameter int            DEPTH    = 4,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    arm_fetch_unit_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = AW + DW;

    fetch_state_t  state_q, state_d;
    logic [AW-1:0] fpc_q, fpc_d;
    logic [AW-1:0] req_pc_q, req_pc_d;
    logic [EW-1:0] last_head_q;
    logic [EW-1:0] head;
    logic [EW-1:0] shown;
    logic [AW-1:0] shown_pc;
    logic [AW-1:0] target;
    logic [CW-1:0] count;
    logic          issue;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;

    assign target = bus.redirect_pc & ~AW'(3);
    assign issue  = (state_q == IDLE) && (count < CW'(DEPTH)) && !bus.redirect_valid;
    assign pop    = !empty && bus.ins_ready;

    always_comb begin
        state_d  = state_q;
        fpc_d    = fpc_q;
        req_pc_d = req_pc_q;
        push     = 1'b0;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d  = WAIT;
                    req_pc_d = fpc_q;
                    fpc_d    = fpc_q + AW'(INS_BYTES);
                end
            end
            WAIT: begin
                if (bus.imem_rvalid) begin
                    state_d = IDLE;
                    push    = !bus.redirect_valid && !full;
                end else if (bus.redirect_valid) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.imem_rvalid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (bus.redirect_valid) fpc_d = target;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            fpc_q    <= RESET_PC;
            req_pc_q <= RESET_PC;
        end else begin
            state_q  <= state_d;
            fpc_q    <= fpc_d;
            req_pc_q <= req_pc_d;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i ({req_pc_q, bus.imem_rdata}),
        .pop_i       (pop),
        .flush_i     (bus.redirect_valid),
        .head_o      (head),
        .count_o     (count),
        .full_o      (full),
        .empty_o     (empty)
    );

    // Decode sees the last head while the queue is empty rather than stale storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_head_q <= '0;
        end else if (!empty) begin
            last_head_q <= head;
        end
    end

    assign shown    = empty ? last_head_q : head;
    assign shown_pc = shown[EW-1:DW];

    assign bus.imem_req     = issue;
    assign bus.imem_addr    = fpc_q;
    assign bus.ins_valid    = !empty;
    assign bus.ins          = shown[DW-1:0];
    assign bus.ins_pc       = shown_pc;
    assign bus.ins_pc_plus4 = shown_pc + AW'(INS_BYTES);

endmodule

// File: tb/tb_arm_fetch_unit.sv
// Self-checking bench for arm_fetch_unit: memory model plus scoreboard of
// expected {pc, word} entries, a cycle table and hand-written corner cases.
module tb_arm_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          keep;
    } pend_t;

    typedef struct {
        bit          ready;
        bit          expReq;
        logic [31:0] expAddr;
        bit          expValid;
        logic [31:0] expPc;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rstB = 1'b1;

    arm_fetch_unit_if #(.AW(32), .DW(32)) busA ();
    arm_fetch_unit_if #(.AW(32), .DW(32)) busB ();

    arm_fetch_unit #(
        .AW(32), .DW(32), .DEPTH(4), .RESET_PC(32'h0000_0000)
    ) dutA (
        .clk (clk),
        .rst (rst),
        .bus (busA)
    );

    arm_fetch_unit #(
        .AW(32), .DW(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)
    ) dutB (
        .clk (clk),
        .rst (rstB),
        .bus (busB)
    );

    always #5 clk = ~clk;

    exp_t        expQ[$];
    pend_t       memQ[$];
    exp_t        expB[$];
    logic [31:0] bAddrs[$];
    int          memLat = 1;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    bit          rstReq = 1'b1;
    bit          readyA = 1'b1;
    bit          redirV = 1'b0;
    logic [31:0] redirPc = '0;
    bit          bPend = 1'b0;
    logic [31:0] bAddr = '0;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h0F0F_3C3C;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One cycle of DUT A: drive inputs at the falling edge, let them settle,
    // then update the memory model and scoreboard.
    task automatic applyStimulus();
        pend_t p;
        bit    rvHit;
        exp_t  e;
        @(negedge clk);
        cyc++;
        rst                 = rstReq;
        busA.ins_ready      = readyA;
        busA.redirect_valid = redirV;
        busA.redirect_pc    = redirPc;
        busA.imem_rvalid    = 1'b0;
        busA.imem_rdata     = 32'hBAD0_BAD0;
        rvHit = 1'b0;
        if (memQ.size() > 0 && memQ[0].due <= cyc) begin
            p = memQ.pop_front();
            rvHit = 1'b1;
            busA.imem_rvalid = 1'b1;
            busA.imem_rdata  = memWord(p.addr);
        end
        #1;
        if (rstReq) begin
            expQ.delete();
            foreach (memQ[i]) memQ[i].keep = 1'b0;
        end else begin
            checkOutput("ins_valid", 32'(busA.ins_valid), 32'(expQ.size() != 0));
            if (busA.ins_valid && busA.ins_ready && expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("ins", busA.ins, e.word);
                checkOutput("ins_pc", busA.ins_pc, e.pc);
                checkOutput("ins_pc_plus4", busA.ins_pc_plus4, e.pc + 32'd4);
            end
            if (redirV) begin
                expQ.delete();
                foreach (memQ[i]) memQ[i].keep = 1'b0;
            end
            if (rvHit && p.keep && !redirV) expQ.push_back('{pc: p.addr, word: memWord(p.addr)});
            if (busA.imem_req) memQ.push_back('{addr: busA.imem_addr, due: cyc + memLat, keep: 1'b1});
        end
    endtask

    task automatic resetA(input int cycles, input bit clearMem);
        if (clearMem) memQ.delete();
        rstReq = 1'b1;
        for (int i = 0; i < cycles; i++) applyStimulus();
        rstReq = 1'b0;
    endtask

    // DUT B: 1-cycle memory, decode always ready, no redirects.
    task automatic stepB();
        exp_t e;
        @(negedge clk);
        rstB                = 1'b0;
        busB.ins_ready      = 1'b1;
        busB.redirect_valid = 1'b0;
        busB.redirect_pc    = '0;
        busB.imem_rvalid    = bPend;
        busB.imem_rdata     = bPend ? memWord(bAddr) : 32'h0;
        #1;
        checkOutput("B ins_valid", 32'(busB.ins_valid), 32'(expB.size() != 0));
        if (busB.ins_valid && expB.size() > 0) begin
            e = expB.pop_front();
            checkOutput("B ins", busB.ins, e.word);
            checkOutput("B ins_pc", busB.ins_pc, e.pc);
            checkOutput("B ins_pc_plus4", busB.ins_pc_plus4, e.pc + 32'd4);
        end
        if (bPend) begin
            expB.push_back('{pc: bAddr, word: memWord(bAddr)});
            bPend = 1'b0;
        end
        if (busB.imem_req) begin
            bAddrs.push_back(busB.imem_addr);
            bAddr = busB.imem_addr;
            bPend = 1'b1;
        end
    endtask

    initial begin
        vec_t        vecs[7];
        logic [31:0] wrapExp[3];
        bit          found;

        vecs[0] = '{ready: 1'b1, expReq: 1'b1, expAddr: 32'h0, expValid: 1'b0, expPc: 32'h0};
        vecs[1] = '{ready: 1'b1, expReq: 1'b0, expAddr: 32'h0, expValid: 1'b0, expPc: 32'h0};
        vecs[2] = '{ready: 1'b1, expReq: 1'b1, expAddr: 32'h4, expValid: 1'b1, expPc: 32'h0};
        vecs[3] = '{ready: 1'b1, expReq: 1'b0, expAddr: 32'h0, expValid: 1'b0, expPc: 32'h0};
        vecs[4] = '{ready: 1'b1, expReq: 1'b1, expAddr: 32'h8, expValid: 1'b1, expPc: 32'h4};
        vecs[5] = '{ready: 1'b1, expReq: 1'b0, expAddr: 32'h0, expValid: 1'b0, expPc: 32'h0};
        vecs[6] = '{ready: 1'b1, expReq: 1'b1, expAddr: 32'hC, expValid: 1'b1, expPc: 32'h8};
        wrapExp[0] = 32'hFFFF_FFF8;
        wrapExp[1] = 32'hFFFF_FFFC;
        wrapExp[2] = 32'h0000_0000;

        busA.imem_rvalid = 1'b0; busA.imem_rdata = '0; busA.redirect_valid = 1'b0;
        busA.redirect_pc = '0;   busA.ins_ready = 1'b1;
        busB.imem_rvalid = 1'b0; busB.imem_rdata = '0; busB.redirect_valid = 1'b0;
        busB.redirect_pc = '0;   busB.ins_ready = 1'b1;

        $display("[TB] reset release, 1-cycle memory");
        resetA(3, 1'b1);
        for (int i = 0; i < 7; i++) begin
            readyA = vecs[i].ready;
            applyStimulus();
            if (i == 0) begin
                checkOutput("reset ins", busA.ins, 32'h0);
                checkOutput("reset ins_pc", busA.ins_pc, 32'h0);
                checkOutput("reset ins_pc_plus4", busA.ins_pc_plus4, 32'h4);
            end
            checkOutput("tbl imem_req", 32'(busA.imem_req), 32'(vecs[i].expReq));
            if (vecs[i].expReq) checkOutput("tbl imem_addr", busA.imem_addr, vecs[i].expAddr);
            checkOutput("tbl ins_valid", 32'(busA.ins_valid), 32'(vecs[i].expValid));
            if (vecs[i].expValid) checkOutput("tbl ins_pc", busA.ins_pc, vecs[i].expPc);
        end

        $display("[TB] backpressure fills the queue");
        readyA = 1'b0;
        resetA(2, 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus();
        checkOutput("full imem_req", 32'(busA.imem_req), 32'h0);
        checkOutput("full count", 32'(dutA.count), 32'd4);
        checkOutput("full head pc", busA.ins_pc, 32'h0);
        readyA = 1'b1;
        applyStimulus();
        checkOutput("pop cycle imem_req", 32'(busA.imem_req), 32'h0);
        readyA = 1'b0;
        applyStimulus();
        checkOutput("refill imem_req", 32'(busA.imem_req), 32'h1);
        checkOutput("refill imem_addr", busA.imem_addr, 32'h10);
        applyStimulus();
        applyStimulus();
        checkOutput("refull imem_req", 32'(busA.imem_req), 32'h0);
        checkOutput("refull count", 32'(dutA.count), 32'd4);

        $display("[TB] redirect during 3-wait-state request");
        readyA = 1'b1;
        memLat = 3;
        resetA(2, 1'b1);
        applyStimulus();
        checkOutput("ws imem_addr", busA.imem_addr, 32'h0);
        redirV = 1'b1;
        redirPc = 32'h0000_0103;
        applyStimulus();
        checkOutput("redir imem_req", 32'(busA.imem_req), 32'h0);
        redirV = 1'b0;
        applyStimulus();
        checkOutput("drain state", 32'(dutA.state_q), 32'(arm_pkg::DRAIN));
        checkOutput("drain imem_req", 32'(busA.imem_req), 32'h0);
        applyStimulus();
        checkOutput("stale cycle imem_req", 32'(busA.imem_req), 32'h0);
        applyStimulus();
        checkOutput("target imem_req", 32'(busA.imem_req), 32'h1);
        checkOutput("target imem_addr", busA.imem_addr, 32'h100);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            applyStimulus();
            if (busA.ins_valid) found = 1'b1;
        end
        checkOutput("target arrives in time", 32'(found), 32'h1);
        checkOutput("target ins_pc", busA.ins_pc, 32'h100);

        $display("[TB] redirect with response and pop in one cycle");
        memLat = 1;
        readyA = 1'b0;
        resetA(2, 1'b1);
        applyStimulus();
        applyStimulus();
        applyStimulus();
        checkOutput("pre head valid", 32'(busA.ins_valid), 32'h1);
        readyA = 1'b1;
        redirV = 1'b1;
        redirPc = 32'h0000_0200;
        applyStimulus();
        redirV = 1'b0;
        applyStimulus();
        checkOutput("post flush count", 32'(dutA.count), 32'h0);
        checkOutput("post flush imem_req", 32'(busA.imem_req), 32'h1);
        checkOutput("post flush imem_addr", busA.imem_addr, 32'h200);

        $display("[TB] reset while waiting, late response");
        memLat = 3;
        resetA(2, 1'b1);
        applyStimulus();
        resetA(2, 1'b0);
        applyStimulus();
        checkOutput("restart imem_req", 32'(busA.imem_req), 32'h1);
        checkOutput("restart imem_addr", busA.imem_addr, 32'h0);
        applyStimulus();
        checkOutput("late rvalid ignored", 32'(busA.ins_valid), 32'h0);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            applyStimulus();
            if (busA.ins_valid) found = 1'b1;
        end
        checkOutput("restart arrives in time", 32'(found), 32'h1);
        checkOutput("restart ins_pc", busA.ins_pc, 32'h0);
        busA.imem_rvalid = 1'b0;

        $display("[TB] address wrap from top of memory");
        stepB();
        checkOutput("B reset ins_pc", busB.ins_pc, 32'h0);
        checkOutput("B reset ins_pc_plus4", busB.ins_pc_plus4, 32'h4);
        for (int i = 0; i < 7; i++) stepB();
        checkOutput("B request count", 32'(bAddrs.size() >= 3), 32'h1);
        for (int i = 0; i < 3; i++)
            checkOutput("B wrap addr", (i < bAddrs.size()) ? bAddrs[i] : 32'hDEAD_DEAD, wrapExp[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
